// File: rtl/iq_pkg.sv
// rtl/iq_pkg.sv - shared widths, entry record and wakeup tag compare for the issue queue
package iq_pkg;

  localparam int IQ_TAG_W    = 6;
  localparam int IQ_PAY_W    = 32;
  localparam int IQ_WB_PORTS = 2;

  // One issue-queue slot; index 0 of rdy/tag is source 1, index 1 is source 2.
  typedef struct packed {
    logic                     valid;
    logic [1:0]               rdy;
    logic [1:0][IQ_TAG_W-1:0] tag;
    logic [IQ_TAG_W-1:0]      dst;
    logic [IQ_PAY_W-1:0]      payload;
  } iq_entry_t;

  // True when any valid writeback port broadcasts the given tag.
  function automatic logic tag_match(
    input logic [IQ_WB_PORTS-1:0]          wb_valid,
    input logic [IQ_WB_PORTS*IQ_TAG_W-1:0] wb_tag,
    input logic [IQ_TAG_W-1:0]             tag
  );
    logic hit;
    hit = 1'b0;
    for (int k = 0; k < IQ_WB_PORTS; k++) begin
      if (wb_valid[k] && (wb_tag[k*IQ_TAG_W +: IQ_TAG_W] == tag)) begin
        hit = 1'b1;
      end
    end
    return hit;
  endfunction

endpackage

// File: rtl/iq_entry.sv
// rtl/iq_entry.sv - one issue-queue slot with wakeup compare, write port and clear-on-grant
module iq_entry
  import iq_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          flush,
  input  logic                          wr_en,
  input  logic [1:0]                    wr_rdy,
  input  logic [1:0][IQ_TAG_W-1:0]      wr_tag,
  input  logic [IQ_TAG_W-1:0]           wr_dst,
  input  logic [IQ_PAY_W-1:0]           wr_payload,
  input  logic [IQ_WB_PORTS-1:0]        wb_valid,
  input  logic [IQ_WB_PORTS*IQ_TAG_W-1:0] wb_tag,
  input  logic                          grant,
  output logic                          valid,
  output logic                          req,
  output logic [IQ_TAG_W-1:0]           dst,
  output logic [IQ_PAY_W-1:0]           payload
);

  iq_entry_t  ent;
  logic [1:0] wr_hit;
  logic [1:0] wake_hit;
  logic       issue;

  // Broadcast compares: against incoming tags for the dispatch bypass, against
  // stored tags for ordinary wakeup.
  always_comb begin
    wr_hit   = '0;
    wake_hit = '0;
    for (int s = 0; s < 2; s++) begin
      wr_hit[s]   = tag_match(wb_valid, wb_tag, wr_tag[s]);
      wake_hit[s] = tag_match(wb_valid, wb_tag, ent.tag[s]);
    end
  end

  // Request depends on stored state only, so wb/dispatch never reach the select tree combinationally.
  assign req     = ent.valid & ent.rdy[0] & ent.rdy[1];
  assign issue   = grant & req;
  assign valid   = ent.valid;
  assign dst     = ent.dst;
  assign payload = ent.payload;

  // Slot state: flush beats everything, a write fills a free slot, otherwise wake up and free on grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent <= '0;
    end else if (flush) begin
      ent.valid <= 1'b0;
      ent.rdy   <= '0;
    end else if (wr_en) begin
      ent.valid   <= 1'b1;
      ent.rdy     <= wr_rdy | wr_hit;
      ent.tag     <= wr_tag;
      ent.dst     <= wr_dst;
      ent.payload <= wr_payload;
    end else if (ent.valid) begin
      if (issue) begin
        ent.valid <= 1'b0;
        ent.rdy   <= '0;
      end else begin
        ent.rdy <= ent.rdy | wake_hit;
      end
    end
  end

endmodule

// File: rtl/issue_queue_wakeup.sv
// rtl/issue_queue_wakeup.sv - issue-queue entry array feeding the select tree, with registered issue port
module issue_queue_wakeup
  import iq_pkg::*;
#(
  parameter int DEPTH    = 8,           // one select quad per 4 entries; keep a multiple of 4
  parameter int TAG_W    = IQ_TAG_W,
  parameter int PAY_W    = IQ_PAY_W,
  parameter int WB_PORTS = IQ_WB_PORTS
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  input  logic                      flush_i,
  input  logic                      disp_valid_i,
  output logic                      disp_ready_o,
  input  logic [TAG_W-1:0]          disp_src1_tag_i,
  input  logic                      disp_src1_rdy_i,
  input  logic [TAG_W-1:0]          disp_src2_tag_i,
  input  logic                      disp_src2_rdy_i,
  input  logic [TAG_W-1:0]          disp_dst_tag_i,
  input  logic [PAY_W-1:0]          disp_payload_i,
  input  logic [WB_PORTS-1:0]       wb_valid_i,
  input  logic [WB_PORTS*TAG_W-1:0] wb_tag_i,
  output logic [DEPTH-1:0]          req_o,
  input  logic [DEPTH-1:0]          grant_i,
  output logic                      issue_valid_o,
  output logic [TAG_W-1:0]          issue_dst_tag_o,
  output logic [PAY_W-1:0]          issue_payload_o
);

  logic [DEPTH-1:0] valid;
  logic [DEPTH-1:0] alloc;
  logic [DEPTH-1:0] grant_eff;
  logic             disp_fire;
  logic             any_grant;
  logic [TAG_W-1:0] ent_dst     [DEPTH];
  logic [PAY_W-1:0] ent_payload [DEPTH];
  logic [TAG_W-1:0] sel_dst;
  logic [PAY_W-1:0] sel_payload;

  // Ready reflects current occupancy only; a slot freed by this cycle's grant counts from next cycle.
  assign disp_ready_o = |(~valid);
  assign disp_fire    = disp_valid_i & disp_ready_o & ~flush_i;

  // Lowest-index free slot receives the dispatched instruction.
  always_comb begin
    logic found;
    alloc = '0;
    found = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (!valid[i] && !found) begin
        alloc[i] = 1'b1;
        found    = 1'b1;
      end
    end
  end

  // Grants to idle slots are dropped here so they neither free a slot nor produce an issue.
  assign grant_eff = grant_i & req_o;
  assign any_grant = |grant_eff;

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    iq_entry u_entry (
      .clk        (clk_i),
      .rst_n      (rst_n_i),
      .flush      (flush_i),
      .wr_en      (disp_fire & alloc[i]),
      .wr_rdy     ({disp_src2_rdy_i, disp_src1_rdy_i}),
      .wr_tag     ({disp_src2_tag_i, disp_src1_tag_i}),
      .wr_dst     (disp_dst_tag_i),
      .wr_payload (disp_payload_i),
      .wb_valid   (wb_valid_i),
      .wb_tag     (wb_tag_i),
      .grant      (grant_i[i]),
      .valid      (valid[i]),
      .req        (req_o[i]),
      .dst        (ent_dst[i]),
      .payload    (ent_payload[i])
    );
  end

  // AND-OR mux keyed by the one-hot grant picks the issuing slot's destination and payload.
  always_comb begin
    sel_dst     = '0;
    sel_payload = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (grant_eff[i]) begin
        sel_dst     = sel_dst | ent_dst[i];
        sel_payload = sel_payload | ent_payload[i];
      end
    end
  end

  // Issue registers: valid pulses once per grant; tag and payload hold between issues.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      issue_valid_o   <= 1'b0;
      issue_dst_tag_o <= '0;
      issue_payload_o <= '0;
    end else if (flush_i) begin
      issue_valid_o <= 1'b0;
    end else begin
      issue_valid_o <= any_grant;
      if (any_grant) begin
        issue_dst_tag_o <= sel_dst;
        issue_payload_o <= sel_payload;
      end
    end
  end

  // A well-formed select tree never grants more than one slot per cycle.
  assert property (@(posedge clk_i) disable iff (!rst_n_i) $onehot0(grant_i));

endmodule

// File: tb/tb_issue_queue_wakeup.sv
// tb/tb_issue_queue_wakeup.sv - directed self-checking bench for issue_queue_wakeup
module tb_issue_queue_wakeup;

  localparam int DEPTH = 8;
  localparam int TAG_W = 6;
  localparam int PAY_W = 32;
  localparam int WBP   = 2;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             disp_valid;
  logic             disp_ready;
  logic [TAG_W-1:0] src1_tag, src2_tag, dst_tag;
  logic             src1_rdy, src2_rdy;
  logic [PAY_W-1:0] payload;
  logic [WBP-1:0]   wb_valid;
  logic [WBP*TAG_W-1:0] wb_tag;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] grant;
  logic [DEPTH-1:0] grant_man;
  logic             auto_grant;
  logic             issue_valid;
  logic [TAG_W-1:0] issue_dst;
  logic [PAY_W-1:0] issue_payload;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign grant = auto_grant ? req : grant_man;

  issue_queue_wakeup #(.DEPTH(DEPTH), .TAG_W(TAG_W), .PAY_W(PAY_W), .WB_PORTS(WBP)) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .flush_i         (flush),
    .disp_valid_i    (disp_valid),
    .disp_ready_o    (disp_ready),
    .disp_src1_tag_i (src1_tag),
    .disp_src1_rdy_i (src1_rdy),
    .disp_src2_tag_i (src2_tag),
    .disp_src2_rdy_i (src2_rdy),
    .disp_dst_tag_i  (dst_tag),
    .disp_payload_i  (payload),
    .wb_valid_i      (wb_valid),
    .wb_tag_i        (wb_tag),
    .req_o           (req),
    .grant_i         (grant),
    .issue_valid_o   (issue_valid),
    .issue_dst_tag_o (issue_dst),
    .issue_payload_o (issue_payload)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_disp(input logic v, input logic [TAG_W-1:0] t1, input logic r1,
                          input logic [TAG_W-1:0] t2, input logic r2,
                          input logic [TAG_W-1:0] d, input logic [PAY_W-1:0] p);
    disp_valid = v;
    src1_tag = t1; src1_rdy = r1;
    src2_tag = t2; src2_rdy = r2;
    dst_tag  = d;  payload  = p;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; auto_grant = 1'b0; grant_man = '0;
    wb_valid = '0; wb_tag = '0;
    set_disp(1'b0, '0, 1'b0, '0, 1'b0, '0, '0);
    #3;
    check("rst_issue_valid", issue_valid, 0);
    check("rst_req", req, 0);
    check("rst_disp_ready", disp_ready, 1);
    check("rst_issue_dst", issue_dst, 0);
    check("rst_issue_payload", issue_payload, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ready dispatch, grant tied to request.
    auto_grant = 1'b1;
    set_disp(1'b1, 6'd1, 1'b1, 6'd2, 1'b1, 6'd5, 32'hA5A5_0001);
    step();
    disp_valid = 1'b0;
    check("t1_req", req, 8'h01);
    check("t1_no_issue_yet", issue_valid, 0);
    step();
    check("t1_issue_valid", issue_valid, 1);
    check("t1_issue_dst", issue_dst, 5);
    check("t1_issue_payload", issue_payload, 32'hA5A5_0001);
    check("t1_freed", req, 0);
    check("t1_disp_ready", disp_ready, 1);
    step();
    check("t1_issue_drop", issue_valid, 0);
    check("t1_dst_hold", issue_dst, 5);
    auto_grant = 1'b0;

    // Wakeup via broadcast two cycles after dispatch.
    set_disp(1'b1, 6'd12, 1'b0, 6'd3, 1'b1, 6'd9, 32'h0000_0009);
    step();
    disp_valid = 1'b0;
    check("t2_req_c0", req, 0);
    step();
    check("t2_req_c1", req, 0);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd12};
    check("t2_req_bcast_cycle", req, 0);
    step();
    wb_valid = '0;
    check("t2_req_woke", req, 8'h01);
    grant_man = 8'h01;
    step();
    grant_man = '0;
    check("t2_issue_dst", issue_dst, 9);
    check("t2_issue_payload", issue_payload, 32'h9);

    // Dispatch-wakeup bypass on wb port 1.
    set_disp(1'b1, 6'd4, 1'b1, 6'd7, 1'b0, 6'd17, 32'h0000_0017);
    wb_valid = 2'b10; wb_tag = {6'd7, 6'd0};
    step();
    disp_valid = 1'b0; wb_valid = '0;
    check("t3_bypass_req", req, 8'h01);
    grant_man = 8'h01;
    step();
    grant_man = '0;
    check("t3_issue_dst", issue_dst, 17);

    // Fill all entries with unready sources, then try a ninth dispatch.
    for (int i = 0; i < DEPTH; i++) begin
      set_disp(1'b1, 6'(20 + i), 1'b0, 6'd1, 1'b1, 6'(30 + i), 32'(i));
      step();
    end
    check("t4_full_ready", disp_ready, 0);
    check("t4_full_req", req, 0);
    set_disp(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd63, 32'hDEAD);
    step();
    disp_valid = 1'b0;
    check("t4_ninth_dropped", req, 0);
    check("t4_still_full", disp_ready, 0);
    wb_valid = 2'b01; wb_tag = {6'd0, 6'd23};
    step();
    wb_valid = '0;
    check("t4_wake3", req, 8'h08);
    grant_man = 8'h08;
    #1;
    check("t4_ready_same_cycle", disp_ready, 0);
    step();
    grant_man = '0;
    check("t4_issue_dst", issue_dst, 33);
    check("t4_ready_after", disp_ready, 1);
    set_disp(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd44, 32'h44);
    step();
    disp_valid = 1'b0;
    check("t4_lands_in_3", req, 8'h08);
    check("t4_full_again", disp_ready, 0);
    grant_man = 8'h08;
    step();
    grant_man = '0;
    check("t4_issue_dst2", issue_dst, 44);
    flush = 1'b1;
    step();
    flush = 1'b0;
    check("t4_flush_req", req, 0);
    check("t4_flush_ready", disp_ready, 1);

    // Flush wins over a same-cycle grant.
    set_disp(1'b1, 6'd50, 1'b0, 6'd1, 1'b1, 6'd10, 32'h10);
    step();
    set_disp(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd11, 32'h11);
    step();
    set_disp(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd12, 32'h12);
    step();
    disp_valid = 1'b0;
    check("t5_req12", req, 8'h06);
    flush = 1'b1; grant_man = 8'h02;
    step();
    flush = 1'b0; grant_man = '0;
    check("t5_issue_valid", issue_valid, 0);
    check("t5_req", req, 0);
    check("t5_disp_ready", disp_ready, 1);
    check("t5_dst_hold", issue_dst, 44);

    // Async reset while an issue is being presented.
    set_disp(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd15, 32'h15);
    step();
    set_disp(1'b1, 6'd1, 1'b1, 6'd1, 1'b1, 6'd16, 32'h16);
    grant_man = 8'h01;
    step();
    disp_valid = 1'b0; grant_man = '0;
    check("t6_issue_valid", issue_valid, 1);
    check("t6_issue_dst", issue_dst, 15);
    check("t6_req", req, 8'h02);
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_issue_valid", issue_valid, 0);
    check("t6_rst_req", req, 0);
    check("t6_rst_disp_ready", disp_ready, 1);
    check("t6_rst_dst", issue_dst, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
